// File: rtl/ntt_coef_unloader.sv
// ntt_coef_unloader
// Drains NTT/INTT result words from the wrap block's read FIFO (normal,
// non-show-ahead read mode) and presents them as an ordered valid/ready
// stream of DW-bit coefficients. The low half of each word is the even
// index and the high half is the odd index, which matches the loader's
// address_ina/address_inb pairing. One start unloads one polynomial.
//
// Optional feature: define NTT_UNLOADER_RANGE_CHECK_EN to build a sticky
// range check that flags any accepted coefficient >= Q on err. When the
// macro is undefined, err is tied low and no comparator is built.

module ntt_coef_unloader #(
   parameter int N_COEF = 256,
   parameter int DW     = 16,
   parameter int Q      = 3329
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            abort,
   input  logic [2*DW-1:0] rd_dat,
   input  logic            rd_empty,
   output logic            rd_req,
   output logic [DW-1:0]   out_coef,
   output logic [7:0]      out_index,
   output logic            out_last,
   output logic            out_valid,
   input  logic            out_ready,
   output logic            busy,
   output logic            done,
   output logic            err
);

   localparam int NWORD = N_COEF / 2;
   localparam int KW    = (NWORD > 1) ? $clog2(NWORD) : 1;

   // Configuration sanity: an odd coefficient count cannot be paired, and
   // a non-positive modulus makes the range check meaningless.
   if ((N_COEF % 2) != 0 || N_COEF < 2 || Q < 1) begin : g_bad_cfg
      $error("ntt_coef_unloader: N_COEF must be even and >= 2, Q must be >= 1");
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_LATCH,
      S_EMIT_LO,
      S_EMIT_HI,
      S_DONE
   } state_t;

   state_t          state_q, state_d;
   logic [KW-1:0]   k_q;
   logic [2*DW-1:0] word_q;
   logic            hs;
   logic            last_word;
   logic [7:0]      idx_base;

   assign hs        = out_valid & out_ready;
   assign last_word = (k_q == KW'(NWORD - 1));
   // Even index of the current word; the odd index just sets bit 0.
   assign idx_base  = 8'({k_q, 1'b0});

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic; abort overrides every transition.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:    if (start)     state_d = S_FETCH;
         S_FETCH:   if (!rd_empty) state_d = S_LATCH;
         S_LATCH:                  state_d = S_EMIT_LO;
         S_EMIT_LO: if (hs)        state_d = S_EMIT_HI;
         S_EMIT_HI: if (hs)        state_d = last_word ? S_DONE : S_FETCH;
         S_DONE:                   state_d = S_IDLE;
         default:                  state_d = S_IDLE;
      endcase
      if (abort) state_d = S_IDLE;
   end

   // Moore-style outputs decoded from the current state. Coefficient and
   // index only change on a state or word change, so they hold steady
   // while the consumer stalls.
   always_comb begin
      rd_req    = 1'b0;
      out_valid = 1'b0;
      out_coef  = '0;
      out_index = '0;
      out_last  = 1'b0;
      busy      = (state_q != S_IDLE);
      done      = (state_q == S_DONE);
      case (state_q)
         S_FETCH: rd_req = !rd_empty;
         S_EMIT_LO: begin
            out_valid = 1'b1;
            out_coef  = word_q[DW-1:0];
            out_index = idx_base;
         end
         S_EMIT_HI: begin
            out_valid = 1'b1;
            out_coef  = word_q[2*DW-1:DW];
            out_index = idx_base | 8'd1;
            out_last  = last_word;
         end
         default: ;
      endcase
   end

   // Word counter: cleared while idle or on abort, advanced after the odd
   // coefficient of a non-final word is accepted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                     k_q <= '0;
      else if (abort || state_q == S_IDLE)         k_q <= '0;
      else if (state_q == S_EMIT_HI && hs && !last_word)
                                                   k_q <= k_q + 1'b1;
   end

   // Word register: FIFO data is valid the cycle after the pop, which is
   // the LATCH cycle. An abort discards the popped word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                              word_q <= '0;
      else if (state_q == S_LATCH && !abort) word_q <= rd_dat;
   end

`ifdef NTT_UNLOADER_RANGE_CHECK_EN
   logic err_q;
   logic out_of_range;

   assign out_of_range = (32'(out_coef) >= 32'(Q));

   // Sticky range flag: cleared by an accepted start, set by any accepted
   // coefficient at or above the modulus.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                      err_q <= 1'b0;
      else if (state_q == S_IDLE && start && !abort) err_q <= 1'b0;
      else if (hs && out_of_range && !abort)        err_q <= 1'b1;
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

endmodule
